// File: rtl/nbr_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nbr_window_gen_pkg
// Purpose  : Shared definitions for the neighbourhood window generator:
//            neighbour count, neighbour bit order, FSM state encoding and a
//            modulo row-address helper.
// Revision : 1.0 - initial release
// ============================================================================
package nbr_window_gen_pkg;

  localparam int NEIGHBOURS_CNT = 8;

  // Bit position of each neighbour inside the neighbour vector.
  typedef enum logic [2:0] {
    NW = 3'd0,
    N  = 3'd1,
    NE = 3'd2,
    W  = 3'd3,
    E  = 3'd4,
    SW = 3'd5,
    S  = 3'd6,
    SE = 3'd7
  } nbr_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    EMIT  = 3'd2,
    FETCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // (value + step) mod modulus, valid for step < modulus and value < modulus.
  // Avoids any power-of-two assumption on the field height.
  function automatic int unsigned wrap_add(input int unsigned value,
                                           input int unsigned step,
                                           input int unsigned modulus);
    int unsigned sum;
    sum = value + step;
    return (sum >= modulus) ? (sum - modulus) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nbr_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : nbr_window_gen_if
// Purpose  : Bundles control, frame-buffer read port and window stream of the
//            neighbourhood window generator.
// Ports    : master = generator side, slave = environment side.
//            i_start/o_busy/o_done      pass control
//            o_rd_en/o_rd_addr/i_rd_data frame-buffer row read (1-cycle latency)
//            o_valid/i_ready            window stream handshake
//            o_nbrs/o_cell_state/o_x/o_y window payload
// Revision : 1.0 - initial release
// ============================================================================
interface nbr_window_gen_if
  import nbr_window_gen_pkg::*;
#(
  parameter int FIELD_W = 16,
  parameter int FIELD_H = 16
);
  localparam int X_W = $clog2(FIELD_W);
  localparam int Y_W = $clog2(FIELD_H);

  logic                      i_start;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_rd_en;
  logic [Y_W-1:0]            o_rd_addr;
  logic [FIELD_W-1:0]        i_rd_data;
  logic                      o_valid;
  logic                      i_ready;
  logic [NEIGHBOURS_CNT-1:0] o_nbrs;
  logic                      o_cell_state;
  logic [X_W-1:0]            o_x;
  logic [Y_W-1:0]            o_y;

  modport master (
    input  i_start, i_rd_data, i_ready,
    output o_busy, o_done, o_rd_en, o_rd_addr,
           o_valid, o_nbrs, o_cell_state, o_x, o_y
  );

  modport slave (
    output i_start, i_rd_data, i_ready,
    input  o_busy, o_done, o_rd_en, o_rd_addr,
           o_valid, o_nbrs, o_cell_state, o_x, o_y
  );

endinterface
`default_nettype wire

// File: rtl/nbr_window_gen_row_select.sv
`default_nettype none
// ============================================================================
// Module   : nbr_row_select
// Purpose  : Combinational 3x3 window extraction from three row registers.
// Ports    : top_row/mid_row/bot_row  rows y-1, y, y+1
//            x                        centre column
//            mask_top/mask_bot        force the whole top/bottom row dead
//            mask_left/mask_right     force column x-1 / x+1 dead
//            nbrs                     8-neighbour vector (package bit order)
//            cell_state               centre cell
// Revision : 1.0 - initial release
// ============================================================================
module nbr_row_select
  import nbr_window_gen_pkg::*;
#(
  parameter int FIELD_W = 16,
  parameter int X_W     = $clog2(FIELD_W)
) (
  input  logic [FIELD_W-1:0]        top_row,
  input  logic [FIELD_W-1:0]        mid_row,
  input  logic [FIELD_W-1:0]        bot_row,
  input  logic [X_W-1:0]            x,
  input  logic                      mask_top,
  input  logic                      mask_bot,
  input  logic                      mask_left,
  input  logic                      mask_right,
  output logic [NEIGHBOURS_CNT-1:0] nbrs,
  output logic                      cell_state
);
  localparam logic [X_W-1:0] X_LAST = X_W'(FIELD_W - 1);

  logic [X_W-1:0]     x_left;
  logic [X_W-1:0]     x_right;
  logic [FIELD_W-1:0] top_eff;
  logic [FIELD_W-1:0] bot_eff;

  always_comb begin
    // Column indices wrap around; the masks decide whether the wrapped
    // column is actually seen.
    x_left   = (x == '0)     ? X_LAST : x - X_W'(1);
    x_right  = (x == X_LAST) ? '0     : x + X_W'(1);
    top_eff  = mask_top ? '0 : top_row;
    bot_eff  = mask_bot ? '0 : bot_row;

    nbrs     = '0;
    nbrs[NW] = top_eff[x_left]  & ~mask_left;
    nbrs[N]  = top_eff[x];
    nbrs[NE] = top_eff[x_right] & ~mask_right;
    nbrs[W]  = mid_row[x_left]  & ~mask_left;
    nbrs[E]  = mid_row[x_right] & ~mask_right;
    nbrs[SW] = bot_eff[x_left]  & ~mask_left;
    nbrs[S]  = bot_eff[x];
    nbrs[SE] = bot_eff[x_right] & ~mask_right;

    cell_state = mid_row[x];
  end

endmodule
`default_nettype wire

// File: rtl/nbr_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : nbr_window_gen
// Purpose  : Walks the field row-major, reading one row per frame-buffer word,
//            and streams each cell's 8-neighbour window over valid/ready.
// Ports    : i_clk  clock
//            i_rst  asynchronous active-high reset
//            bus    nbr_window_gen_if.master (control, row read, window stream)
// Revision : 1.0 - initial release
// ============================================================================
module nbr_window_gen
  import nbr_window_gen_pkg::*;
#(
  parameter int FIELD_W = 16,
  parameter int FIELD_H = 16,
  parameter int WRAP    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nbr_window_gen_if.master bus
);
  localparam int X_W = $clog2(FIELD_W);
  localparam int Y_W = $clog2(FIELD_H);
  localparam logic [X_W-1:0] X_LAST = X_W'(FIELD_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(FIELD_H - 1);

  if (NEIGHBOURS_CNT != 8) begin : g_bad_nbrs
    $error("NEIGHBOURS_CNT must be 8");
  end
  if (FIELD_W < 3) begin : g_bad_width
    $error("FIELD_W must be >= 3");
  end
  if (FIELD_H < 3) begin : g_bad_height
    $error("FIELD_H must be >= 3");
  end

  state_t             state;
  logic [2:0]         phase;
  logic [FIELD_W-1:0] top_row;
  logic [FIELD_W-1:0] mid_row;
  logic [FIELD_W-1:0] bot_row;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               busy;
  logic               done;
  logic               valid;
  logic               rd_en;
  logic [Y_W-1:0]     rd_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      phase   <= '0;
      top_row <= '0;
      mid_row <= '0;
      bot_row <= '0;
      x       <= '0;
      y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state <= PRIME;
            busy  <= 1'b1;
            x     <= '0;
            y     <= '0;
            phase <= '0;
          end
        end
        // Phases 0..2 issue reads of rows H-1, 0, 1; each row returns one
        // cycle after its strobe and is captured in phases 2..4.
        PRIME: begin
          phase <= phase + 3'd1;
          case (phase)
            3'd0: begin
              rd_en   <= 1'b1;
              rd_addr <= Y_LAST;
            end
            3'd1: begin
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
            3'd2: begin
              rd_en   <= 1'b1;
              rd_addr <= Y_W'(1);
              top_row <= bus.i_rd_data;
            end
            3'd3: begin
              mid_row <= bus.i_rd_data;
            end
            default: begin
              bot_row <= bus.i_rd_data;
              valid   <= 1'b1;
              state   <= EMIT;
            end
          endcase
        end
        EMIT: begin
          if (bus.i_ready) begin
            if (x == X_LAST) begin
              valid <= 1'b0;
              if (y == Y_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                // Shift rows and issue the next read on the accept edge
                // itself so the row boundary costs only two bubbles.
                state   <= FETCH;
                phase   <= '0;
                top_row <= mid_row;
                mid_row <= bot_row;
                rd_en   <= 1'b1;
                rd_addr <= Y_W'(wrap_add(32'(y), 32'd2, FIELD_H));
              end
            end else begin
              x <= x + X_W'(1);
            end
          end
        end
        FETCH: begin
          phase <= phase + 3'd1;
          if (phase == 3'd1) begin
            bot_row <= bus.i_rd_data;
            y       <= y + Y_W'(1);
            x       <= '0;
            valid   <= 1'b1;
            state   <= EMIT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic no_wrap;
  assign no_wrap = (WRAP == 0);

  nbr_row_select #(
    .FIELD_W (FIELD_W),
    .X_W     (X_W)
  ) u_row_select (
    .top_row    (top_row),
    .mid_row    (mid_row),
    .bot_row    (bot_row),
    .x          (x),
    .mask_top   (no_wrap && (y == '0)),
    .mask_bot   (no_wrap && (y == Y_LAST)),
    .mask_left  (no_wrap && (x == '0)),
    .mask_right (no_wrap && (x == X_LAST)),
    .nbrs       (bus.o_nbrs),
    .cell_state (bus.o_cell_state)
  );

  assign bus.o_busy    = busy;
  assign bus.o_done    = done;
  assign bus.o_valid   = valid;
  assign bus.o_rd_en   = rd_en;
  assign bus.o_rd_addr = rd_addr;
  assign bus.o_x       = x;
  assign bus.o_y       = y;

endmodule
`default_nettype wire

// File: tb/tb_nbr_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nbr_window_gen
// Purpose  : Self-checking bench: three generator instances (4x4 wrap,
//            4x4 no-wrap, 16x16 wrap) against a neighbourhood model computed
//            directly from the field contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nbr_window_gen;

  bit clk = 1'b0;
  bit rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance geometry
  int fw  [3] = '{4, 4, 16};
  int fh  [3] = '{4, 4, 16};
  int wrp [3] = '{1, 0, 1};

  bit       fld [3][16][16];       // [inst][y][x]
  bit [2:0] st       = '0;
  bit [2:0] rdy      = '0;
  bit [2:0] rnd_rdy  = '0;
  bit [2:0] rnd_bit  = '0;
  always @(posedge clk) rnd_bit <= 3'($urandom);

  // Observation state, owned by the compare process
  int       ex [3], ey [3], beats [3], done_cnt [3], first_vcyc [3];
  bit       last_final [3], seen_valid [3];
  int       acc_cyc [3][256];
  logic [8:0] cap [3][16][16];
  // Read log, owned by the frame-buffer process
  int       rd_cnt [3];
  int       rd_log [3][32];

  nbr_window_gen_if #(.FIELD_W(4),  .FIELD_H(4))  if0 ();
  nbr_window_gen_if #(.FIELD_W(4),  .FIELD_H(4))  if1 ();
  nbr_window_gen_if #(.FIELD_W(16), .FIELD_H(16)) if2 ();

  nbr_window_gen #(.FIELD_W(4),  .FIELD_H(4),  .WRAP(1)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  nbr_window_gen #(.FIELD_W(4),  .FIELD_H(4),  .WRAP(0)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  nbr_window_gen #(.FIELD_W(16), .FIELD_H(16), .WRAP(1)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  assign if0.i_start = st[0];
  assign if1.i_start = st[1];
  assign if2.i_start = st[2];
  assign if0.i_ready = rnd_rdy[0] ? rnd_bit[0] : rdy[0];
  assign if1.i_ready = rnd_rdy[1] ? rnd_bit[1] : rdy[1];
  assign if2.i_ready = rnd_rdy[2] ? rnd_bit[2] : rdy[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference window: {centre, nbrs} from the field by plain coordinate math.
  function automatic logic [8:0] model(input int i, input int x, input int y);
    int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    logic [8:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int nx, ny;
      nx = x + dx[k];
      ny = y + dy[k];
      if (wrp[i] != 0) begin
        nx = (nx + fw[i]) % fw[i];
        ny = (ny + fh[i]) % fh[i];
      end
      if (nx >= 0 && nx < fw[i] && ny >= 0 && ny < fh[i]) r[k] = fld[i][ny][nx];
    end
    r[8] = fld[i][y][x];
    return r;
  endfunction

  // Frame buffer: data for a strobed row appears the following cycle,
  // otherwise random garbage.
  function automatic logic [15:0] fb_data(input int i, input bit en, input int addr,
                                          input bit start, input bit busy);
    logic [15:0] d;
    d = 16'($urandom);
    if (start && !busy) rd_cnt[i] = 0;
    if (en) begin
      for (int x = 0; x < fw[i]; x++) d[x] = fld[i][addr % 16][x];
      if (rd_cnt[i] < 32) rd_log[i][rd_cnt[i]] = addr;
      rd_cnt[i]++;
    end
    return d;
  endfunction

  always @(posedge clk) begin
    if0.i_rd_data <= 4'(fb_data(0, if0.o_rd_en, int'(if0.o_rd_addr), st[0], if0.o_busy));
    if1.i_rd_data <= 4'(fb_data(1, if1.o_rd_en, int'(if1.o_rd_addr), st[1], if1.o_busy));
    if2.i_rd_data <= fb_data(2, if2.o_rd_en, int'(if2.o_rd_addr), st[2], if2.o_busy);
  end

  task automatic observe(input int i, input bit v, input bit r, input bit d,
                         input logic [7:0] nb, input bit c, input int x, input int y);
    if (rst) begin
      ex[i] = 0; ey[i] = 0; beats[i] = 0; last_final[i] = 0; seen_valid[i] = 0;
      return;
    end
    if (d || last_final[i]) chk($sformatf("done_pulse%0d", i), int'(d), int'(last_final[i]));
    if (d) begin
      chk($sformatf("pass_beats%0d", i), beats[i], fw[i] * fh[i]);
      done_cnt[i]++;
      beats[i] = 0; seen_valid[i] = 0; ex[i] = 0; ey[i] = 0;
    end
    last_final[i] = 0;
    if (v) begin
      if (!seen_valid[i]) begin
        seen_valid[i] = 1;
        first_vcyc[i] = cyc;
      end
      chk($sformatf("order%0d", i), x * 256 + y, ex[i] * 256 + ey[i]);
      chk($sformatf("window%0d_x%0d_y%0d", i, ex[i], ey[i]), int'({c, nb}), int'(model(i, ex[i], ey[i])));
      cap[i][ey[i]][ex[i]] = {c, nb};
      if (r) begin
        if (beats[i] < 256) acc_cyc[i][beats[i]] = cyc;
        beats[i]++;
        last_final[i] = (ex[i] == fw[i] - 1) && (ey[i] == fh[i] - 1);
        ex[i]++;
        if (ex[i] == fw[i]) begin ex[i] = 0; ey[i]++; end
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, if0.o_valid, if0.i_ready, if0.o_done, if0.o_nbrs, if0.o_cell_state, int'(if0.o_x), int'(if0.o_y));
    observe(1, if1.o_valid, if1.i_ready, if1.o_done, if1.o_nbrs, if1.o_cell_state, int'(if1.o_x), int'(if1.o_y));
    observe(2, if2.o_valid, if2.i_ready, if2.o_done, if2.o_nbrs, if2.o_cell_state, int'(if2.o_x), int'(if2.o_y));
  end

  task automatic clear_field(input int i);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) fld[i][y][x] = 1'b0;
  endtask

  task automatic fill_rand(input int i);
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) fld[i][y][x] = 1'($urandom_range(0, 1));
  endtask

  task automatic start_pass(input int i, output int s);
    @(posedge clk); #1 st[i] = 1'b1;
    @(posedge clk); #1 st[i] = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int i, input int budget);
    int d0;
    bit got;
    d0 = done_cnt[i];
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk);
      if (done_cnt[i] != d0) got = 1;
    end
    chk($sformatf("pass_finished%0d", i), int'(got), 1);
  endtask

  // Leaves the caller 2 time units after the edge that presented (x,y).
  task automatic wait_at0(input int x, input int y, input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #2;
      if (if0.o_valid && int'(if0.o_x) == x && int'(if0.o_y) == y) got = 1;
    end
    chk($sformatf("reach0_x%0d_y%0d", x, y), int'(got), 1);
  endtask

  initial begin
    int s;
    int ea [6] = '{3, 0, 1, 2, 3, 0};
    logic [7:0] hold_n;
    int d0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_if0", int'({if0.o_busy, if0.o_done, if0.o_rd_en, if0.o_valid, if0.o_nbrs,
                           if0.o_cell_state, if0.o_x, if0.o_y, if0.o_rd_addr}), 0);
    chk("reset_if1", int'({if1.o_busy, if1.o_done, if1.o_rd_en, if1.o_valid, if1.o_nbrs,
                           if1.o_cell_state, if1.o_x, if1.o_y, if1.o_rd_addr}), 0);
    chk("reset_if2", int'({if2.o_busy, if2.o_done, if2.o_rd_en, if2.o_valid, if2.o_nbrs,
                           if2.o_cell_state, if2.o_x, if2.o_y, if2.o_rd_addr}), 0);
    @(posedge clk); #3 rst = 1'b0;

    // Single live cell at (1,1), wrap, always ready
    clear_field(0);
    fld[0][1][1] = 1'b1;
    chk("model_pin_00", int'(model(0, 0, 0)), 'h080);
    chk("model_pin_22", int'(model(0, 2, 2)), 'h001);
    chk("model_pin_11", int'(model(0, 1, 1)), 'h100);
    rdy[0] = 1'b1;
    start_pass(0, s);
    wait_done(0, 200);
    chk("first_valid_latency", first_vcyc[0] - s, 5);
    chk("read_count", rd_cnt[0], 6);
    for (int k = 0; k < 6; k++) chk($sformatf("read_addr%0d", k), rd_log[0][k], ea[k]);
    for (int k = 1; k < 16; k++) chk($sformatf("beat_gap%0d", k), acc_cyc[0][k] - acc_cyc[0][k-1], (k % 4 == 0) ? 3 : 1);
    chk("single_x0_y0", int'(cap[0][0][0]), 'h080);
    chk("single_x2_y2", int'(cap[0][2][2]), 'h001);
    chk("single_x1_y1", int'(cap[0][1][1]), 'h100);
    repeat (2) @(posedge clk);
    #2 chk("idle_after_done", int'({if0.o_busy, if0.o_valid}), 0);

    // Corner cell at (3,3), wrap and no-wrap
    clear_field(0); fld[0][3][3] = 1'b1;
    clear_field(1); fld[1][3][3] = 1'b1;
    chk("model_pin_corner", int'(model(0, 0, 3)), 'h008);
    rdy[1] = 1'b1;
    start_pass(0, s); wait_done(0, 200);
    start_pass(1, s); wait_done(1, 200);
    chk("corner_wrap_x0_y0", int'(cap[0][0][0]), 'h001);
    chk("corner_wrap_x0_y3", int'(cap[0][3][0]), 'h008);
    chk("corner_wrap_x3_y0", int'(cap[0][0][3]), 'h002);
    chk("corner_nowrap_x0_y0", int'(cap[1][0][0]), 'h000);
    chk("corner_nowrap_x0_y3", int'(cap[1][3][0]), 'h000);
    chk("corner_nowrap_x3_y0", int'(cap[1][0][3]), 'h000);

    // Backpressure at (2,0), then random ready with a start pulse mid-pass
    fill_rand(0);
    rdy[0] = 1'b0;
    start_pass(0, s);
    wait_at0(0, 0, 20);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rdy[0] = 1'b0;
    #1 hold_n = if0.o_nbrs;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d", k), int'({if0.o_valid, if0.o_x, if0.o_y, if0.o_nbrs}),
          int'({1'b1, 2'd2, 2'd0, hold_n}));
      @(posedge clk); #2;
    end
    rdy[0] = 1'b1;
    @(posedge clk); #1 rdy[0] = 1'b0;
    #1 chk("bp_advance", int'({if0.o_valid, if0.o_x, if0.o_y}), int'({1'b1, 2'd3, 2'd0}));
    rnd_rdy[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    wait_done(0, 400);
    rnd_rdy[0] = 1'b0;

    // Reset in the middle of a pass at (1,2)
    rdy[0] = 1'b1;
    start_pass(0, s);
    wait_at0(1, 2, 40);
    #1 rst = 1'b1;
    #1 chk("async_reset", int'({if0.o_valid, if0.o_busy, if0.o_rd_en}), 0);
    d0 = done_cnt[0];
    @(posedge clk); #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("no_done_after_abort", done_cnt[0], d0);
    start_pass(0, s);
    wait_done(0, 200);
    chk("clean_pass_after_abort", done_cnt[0], d0 + 1);

    // Random fields with random backpressure on both small instances
    for (int p = 0; p < 3; p++) begin
      fill_rand(0); fill_rand(1);
      rnd_rdy[1:0] = 2'b11;
      start_pass(0, s); wait_done(0, 400);
      start_pass(1, s); wait_done(1, 400);
    end
    rnd_rdy[1:0] = 2'b00;

    // Full 16x16 field, first always ready, then random ready
    fill_rand(2);
    rdy[2] = 1'b1;
    start_pass(2, s); wait_done(2, 1000);
    chk("read_count_16", rd_cnt[2], 18);
    fill_rand(2);
    rnd_rdy[2] = 1'b1;
    start_pass(2, s); wait_done(2, 3000);
    chk("read_count_16_rnd", rd_cnt[2], 18);
    rnd_rdy[2] = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
